// File: rtl/fetch_stage_skid.sv
// Instruction fetch stage: PC register, instruction-memory read handshake,
// branch-predictor next-PC and a single registered instruction slot toward execute.
module fetch_stage_skid #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic        imem_busy,
    input  logic [31:0] imem_rdata,
    input  logic        predict_taken,
    input  logic [31:0] predict_target,
    input  logic        redirect,
    input  logic [31:0] brj_addr,
    input  logic        stall_ex,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc4,
    output logic [31:0] out_prediction
);

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] save_q, save_d;
    logic        inflight_q, inflight_d;
    logic        valid_q, valid_d;
    logic [31:0] opc_q, opc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] pred_q, pred_d;

    logic [31:0] brj_al;
    logic [31:0] tgt_al;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        consume;
    logic        slot_free;
    logic        ren_int;
    logic        complete;

    assign brj_al    = {brj_addr[31:2], 2'b00};
    assign tgt_al    = {predict_target[31:2], 2'b00};
    assign pc_plus4  = pc_q + 32'd4;
    assign next_pc   = predict_taken ? tgt_al : pc_plus4;

    assign consume   = valid_q && !stall_ex;
    assign slot_free = !valid_q || consume;
    assign ren_int   = (state_q == DRAIN) || slot_free || inflight_q;
    assign complete  = ren_int && !imem_busy;

    // Gating with nRST makes the request fall immediately when reset asserts.
    assign imem_ren  = nRST && ren_int;
    // pc is frozen while a discarded read drains, so it is also the held address.
    assign imem_addr = pc_q;

    assign out_valid      = valid_q;
    assign out_pc         = opc_q;
    assign out_instr      = instr_q;
    assign out_pc4        = pc4_q;
    assign out_prediction = pred_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        save_d     = save_q;
        valid_d    = valid_q;
        opc_d      = opc_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        pred_d     = pred_q;
        inflight_d = ren_int && imem_busy;

        case (state_q)
            FETCH: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    if (ren_int && imem_busy) begin
                        save_d  = brj_al;
                        state_d = DRAIN;
                    end else begin
                        pc_d = brj_al;
                    end
                end else if (complete) begin
                    valid_d = 1'b1;
                    opc_d   = pc_q;
                    instr_d = imem_rdata;
                    pc4_d   = pc_plus4;
                    pred_d  = next_pc;
                    pc_d    = next_pc;
                end else if (consume) begin
                    valid_d = 1'b0;
                end
            end
            DRAIN: begin
                valid_d = 1'b0;
                if (redirect) begin
                    save_d = brj_al;
                end
                if (!imem_busy) begin
                    pc_d    = redirect ? brj_al : save_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            save_q     <= 32'd0;
            inflight_q <= 1'b0;
            valid_q    <= 1'b0;
            opc_q      <= 32'd0;
            instr_q    <= 32'd0;
            pc4_q      <= 32'd0;
            pred_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            save_q     <= save_d;
            inflight_q <= inflight_d;
            valid_q    <= valid_d;
            opc_q      <= opc_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            pred_q     <= pred_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage_skid.sv
// Bench for fetch_stage_skid: directed vector table, random traffic against an
// instruction-stream scoreboard, and an asynchronous reset mid-read.
module tb_fetch_stage_skid;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        imem_busy;
    logic [31:0] imem_rdata;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        redirect;
    logic [31:0] brj_addr;
    logic        stall_ex;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic [31:0] out_prediction;

    logic        rand_mode;
    logic        tbl_pt;
    logic [31:0] tbl_ptgt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    fetch_stage_skid #(.RESET_PC(32'h0000_0200)) dut (
        .CLK(CLK), .nRST(nRST),
        .imem_ren(imem_ren), .imem_addr(imem_addr), .imem_busy(imem_busy), .imem_rdata(imem_rdata),
        .predict_taken(predict_taken), .predict_target(predict_target),
        .redirect(redirect), .brj_addr(brj_addr), .stall_ex(stall_ex),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_pc4(out_pc4), .out_prediction(out_prediction)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
    endfunction

    function automatic logic ptaken(input logic [31:0] a);
        return a[4:2] == 3'd5;
    endfunction

    function automatic logic [31:0] ptgt(input logic [31:0] a);
        return (a + 32'h0000_0140) | 32'h0000_0003;
    endfunction

    // Architectural next pc the predictor implies for an aligned pc.
    function automatic logic [31:0] ref_next(input logic [31:0] p);
        return ptaken(p) ? ((p + 32'h0000_0140) & 32'hFFFF_FFFC) : p + 32'd4;
    endfunction

    assign predict_taken  = rand_mode ? ptaken(imem_addr) : tbl_pt;
    assign predict_target = rand_mode ? ptgt(imem_addr)   : tbl_ptgt;
    assign imem_rdata     = imem_busy ? 32'hDEAD_BEEF : memf(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic        busy;
        logic        pt;
        logic [31:0] brj;
        logic [31:0] tgt;
        logic        e_ren;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_pred;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input logic b, input logic p,
                                input logic [31:0] brj, input logic [31:0] tgt,
                                input logic er, input logic [31:0] ea, input logic eo,
                                input logic [31:0] ep, input logic [31:0] epr);
        vec_t v;
        v.stall = s; v.redir = r; v.busy = b; v.pt = p; v.brj = brj; v.tgt = tgt;
        v.e_ren = er; v.e_addr = ea; v.e_ov = eo; v.e_pc = ep; v.e_pred = epr;
        return v;
    endfunction

    vec_t tv[19];

    logic [31:0] exp_pc;
    logic [31:0] pend_addr;
    logic        pend;
    int          wcnt;
    int          idle;
    int          n_cons;

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        #2;
        chk("rst_ren", 32'(imem_ren), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'h200);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_pc4", out_pc4, 32'd0);
        chk("rst_out_pred", out_prediction, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        //           st r  b  pt brj          tgt          ren addr         ov pc           pred
        tv[0]  = mk(0, 0, 0, 0, 32'h0,       32'h0,       1, 32'h200, 0, 32'h0,   32'h0);
        tv[1]  = mk(0, 0, 0, 0, 32'h0,       32'h0,       1, 32'h204, 1, 32'h200, 32'h204);
        tv[2]  = mk(1, 0, 0, 0, 32'h0,       32'h0,       0, 32'h208, 1, 32'h204, 32'h208);
        tv[3]  = mk(1, 0, 0, 0, 32'h0,       32'h0,       0, 32'h208, 1, 32'h204, 32'h208);
        tv[4]  = mk(1, 0, 0, 0, 32'h0,       32'h0,       0, 32'h208, 1, 32'h204, 32'h208);
        tv[5]  = mk(0, 0, 0, 0, 32'h0,       32'h0,       1, 32'h208, 1, 32'h204, 32'h208);
        tv[6]  = mk(0, 0, 0, 1, 32'h0,       32'h403,     1, 32'h20C, 1, 32'h208, 32'h20C);
        tv[7]  = mk(0, 1, 1, 0, 32'h800,     32'h0,       1, 32'h400, 1, 32'h20C, 32'h400);
        tv[8]  = mk(0, 0, 1, 0, 32'h0,       32'h0,       1, 32'h400, 0, 32'h0,   32'h0);
        tv[9]  = mk(0, 1, 1, 0, 32'h900,     32'h0,       1, 32'h400, 0, 32'h0,   32'h0);
        tv[10] = mk(0, 0, 0, 0, 32'h0,       32'h0,       1, 32'h400, 0, 32'h0,   32'h0);
        tv[11] = mk(0, 0, 0, 0, 32'h0,       32'h0,       1, 32'h900, 0, 32'h0,   32'h0);
        tv[12] = mk(0, 0, 1, 0, 32'h0,       32'h0,       1, 32'h904, 1, 32'h900, 32'h904);
        tv[13] = mk(1, 1, 0, 0, 32'h803,     32'h0,       1, 32'h904, 0, 32'h0,   32'h0);
        tv[14] = mk(0, 0, 0, 0, 32'h0,       32'h0,       1, 32'h800, 0, 32'h0,   32'h0);
        tv[15] = mk(0, 0, 0, 0, 32'h0,       32'h0,       1, 32'h804, 1, 32'h800, 32'h804);
        tv[16] = mk(1, 1, 0, 0, 32'hA02,     32'h0,       0, 32'h808, 1, 32'h804, 32'h808);
        tv[17] = mk(1, 0, 0, 0, 32'h0,       32'h0,       1, 32'hA00, 0, 32'h0,   32'h0);
        tv[18] = mk(0, 0, 0, 0, 32'h0,       32'h0,       1, 32'hA04, 1, 32'hA00, 32'hA04);

        rand_mode = 1'b0;
        tbl_pt    = 1'b0;
        tbl_ptgt  = 32'h0;
        stall_ex  = 1'b0;
        redirect  = 1'b0;
        brj_addr  = 32'h0;
        imem_busy = 1'b0;
        nRST      = 1'b0;
        #1;
        do_reset();

        for (int i = 0; i < 19; i++) begin
            if (i != 0) @(negedge CLK);
            stall_ex  = tv[i].stall;
            redirect  = tv[i].redir;
            imem_busy = tv[i].busy;
            tbl_pt    = tv[i].pt;
            brj_addr  = tv[i].brj;
            tbl_ptgt  = tv[i].tgt;
            #1;
            chk($sformatf("v%0d_ren", i), 32'(imem_ren), 32'(tv[i].e_ren));
            chk($sformatf("v%0d_addr", i), imem_addr, tv[i].e_addr);
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tv[i].e_ov));
            if (tv[i].e_ov) begin
                chk($sformatf("v%0d_pc", i), out_pc, tv[i].e_pc);
                chk($sformatf("v%0d_pc4", i), out_pc4, tv[i].e_pc + 32'd4);
                chk($sformatf("v%0d_instr", i), out_instr, memf(tv[i].e_pc));
                chk($sformatf("v%0d_pred", i), out_prediction, tv[i].e_pred);
            end
        end

        // Random traffic: every instruction execute accepts must follow the
        // predicted stream, restarted at the aligned target of the latest redirect.
        stall_ex = 1'b0; redirect = 1'b0; imem_busy = 1'b0; tbl_pt = 1'b0;
        do_reset();
        rand_mode = 1'b1;
        exp_pc = 32'h200;
        wcnt = 0; pend = 1'b0; pend_addr = 32'h0; idle = 0; n_cons = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c != 0) @(negedge CLK);
            stall_ex  = ($urandom_range(3) == 0);
            redirect  = ($urandom_range(11) == 0);
            brj_addr  = $urandom;
            imem_busy = (wcnt != 0);
            #1;
            if (pend) begin
                chk("hold_ren", 32'(imem_ren), 32'd1);
                chk("hold_addr", imem_addr, pend_addr);
            end
            if (redirect) begin
                exp_pc = brj_addr & 32'hFFFF_FFFC;
                idle = 0;
            end else if (out_valid && !stall_ex) begin
                chk("rnd_pc", out_pc, exp_pc);
                chk("rnd_instr", out_instr, memf(exp_pc));
                chk("rnd_pc4", out_pc4, exp_pc + 32'd4);
                chk("rnd_pred", out_prediction, ref_next(exp_pc));
                exp_pc = ref_next(exp_pc);
                idle = 0;
                n_cons++;
            end else begin
                idle++;
            end
            if (idle > 60) begin
                n_cmp++; n_err++;
                $display("FAIL stuck: no instruction delivered in %0d cycles, expected pc %h", idle, exp_pc);
                idle = 0;
            end
            pend = imem_ren && imem_busy;
            pend_addr = imem_addr;
            if (imem_ren) begin
                if (imem_busy) wcnt--;
                else wcnt = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(3));
            end
        end
        n_cmp++;
        if (n_cons < 500) begin
            n_err++;
            $display("FAIL throughput: got %0d instructions, required at least 500", n_cons);
        end

        // Reset asserted while a read is stalled in memory.
        @(negedge CLK);
        rand_mode = 1'b0; tbl_pt = 1'b0; stall_ex = 1'b0; redirect = 1'b0; imem_busy = 1'b1;
        #1;
        chk("mid_ren_before", 32'(imem_ren), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("mid_ren_drop", 32'(imem_ren), 32'd0);
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_addr", imem_addr, 32'h200);
        chk("mid_out_pc", out_pc, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        imem_busy = 1'b0;
        #1;
        chk("post_rst_ren", 32'(imem_ren), 32'd1);
        chk("post_rst_addr", imem_addr, 32'h200);
        @(negedge CLK);
        #1;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_pc", out_pc, 32'h200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
